// File: rtl/dcache.sv
`timescale 1ns/1ps
// Direct-mapped, write-back, write-allocate data cache with 128-bit lines.
// A miss stalls the CPU, writes back a dirty victim, then fetches the line over a req/busy handshake.
module dcache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MEMREAD,
    input  logic         MEMWRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSY,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSY
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    logic [1:0]       r_state;
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [127:0]     r_data [LINES];
    logic [31:4]      r_miss_addr;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [INDEX_BITS-1:0] w_miss_index;
    logic [TAG_W-1:0]      w_tag;
    logic [TAG_W-1:0]      w_miss_tag;
    logic                  w_req;
    logic                  w_idle;
    logic                  w_hit;
    logic                  w_wr_hit;
    logic                  w_miss;
    logic                  w_mem_done;
    logic [31:0]           w_word;
    logic                  w_unused;

    assign w_offset     = ADDRESS[3:2];
    assign w_index      = ADDRESS[4 +: INDEX_BITS];
    assign w_tag        = ADDRESS[31 -: TAG_W];
    assign w_miss_index = r_miss_addr[4 +: INDEX_BITS];
    assign w_miss_tag   = r_miss_addr[31 -: TAG_W];
    assign w_unused     = &{1'b0, ADDRESS[1:0]};

    // A request seen while RESET is high is ignored so the CPU is never stalled during reset.
    assign w_req      = (MEMREAD | MEMWRITE) & ~RESET;
    assign w_idle     = (r_state == S_IDLE);
    assign w_hit      = w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_wr_hit   = w_idle & w_hit & MEMWRITE;
    assign w_miss     = w_idle & w_req & ~w_hit;
    assign w_mem_done = ~MEM_BUSY;
    assign w_word     = r_data[w_index][{w_offset, 5'd0} +: 32];

    assign READDATA  = (w_idle & w_hit & MEMREAD & ~MEMWRITE) ? w_word : 32'd0;
    assign BUSY      = ~w_idle | w_miss;
    assign MEM_WRITE = (r_state == S_WRITEBACK);
    assign MEM_READ  = (r_state == S_ALLOCATE);

    // Memory-side address and data come only from the state and the latched miss address.
    always_comb begin
        MEM_ADDRESS   = 28'd0;
        MEM_WRITEDATA = 128'd0;
        if (MEM_WRITE) begin
            MEM_ADDRESS   = {r_tag[w_miss_index], w_miss_index};
            MEM_WRITEDATA = r_data[w_miss_index];
        end else if (MEM_READ) begin
            MEM_ADDRESS   = r_miss_addr;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state <= (r_valid[w_index] & r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
                    end else if (w_wr_hit) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (w_mem_done) begin
                        r_state <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (w_mem_done) begin
                        r_state               <= S_IDLE;
                        r_valid[w_miss_index] <= 1'b1;
                        r_dirty[w_miss_index] <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays and the miss address are not reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (w_miss) begin
            r_miss_addr <= ADDRESS[31:4];
        end
        if (w_wr_hit) begin
            r_data[w_index][{w_offset, 5'd0} +: 32] <= WRITEDATA;
        end
        if (MEM_READ && w_mem_done) begin
            r_data[w_miss_index] <= MEM_READDATA;
            r_tag[w_miss_index]  <= w_miss_tag;
        end
    end
endmodule
